// File: rtl/transpose_pkg.sv
// transpose_pkg
// Shared definitions for the runtime-dimensioned matrix transpose engine.
//   state_t    : engine states (IDLE, RUN, FLUSH, DONE)
//   addr_width : address width needed to cover a rows x cols element space
//   DEF_*      : default element width and maximum dimensions
package transpose_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_MAX_ROWS = 16;
  localparam int DEF_MAX_COLS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Clamped to at least one bit so a 1x1 build still has a legal address bus.
  function automatic int addr_width(input int rows, input int cols);
    int cells;
    cells = rows * cols;
    return (cells <= 2) ? 1 : $clog2(cells);
  endfunction

endpackage

// File: rtl/transpose_addr_gen.sv
// transpose_addr_gen
// Address generator for the transpose engine. Walks the source matrix
// row-major and produces the matching destination (transposed) address.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : latch rows/cols and restart the walk at element (0,0)
//   advance   : one read has been issued; step to the next element
//   rows/cols : source matrix dimensions, sampled on start
//   rd_addr   : source address of the current element (i*cols+j)
//   wr_addr   : destination address of the current element (j*rows+i)
//   last      : current element is (rows-1, cols-1)
module transpose_addr_gen
  import transpose_pkg::*;
#(
  parameter int MAX_ROWS = DEF_MAX_ROWS,
  parameter int MAX_COLS = DEF_MAX_COLS,
  parameter int AW       = addr_width(MAX_ROWS, MAX_COLS),
  localparam int RW      = $clog2(MAX_ROWS + 1),
  localparam int CW      = $clog2(MAX_COLS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          advance,
  input  logic [RW-1:0] rows,
  input  logic [CW-1:0] cols,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] wr_addr,
  output logic          last
);

  logic [RW-1:0] rows_q;
  logic [RW-1:0] i_q;
  logic [CW-1:0] cols_q;
  logic [CW-1:0] j_q;
  logic          col_wrap;

  assign col_wrap = (j_q == cols_q - CW'(1));
  assign last     = col_wrap && (i_q == rows_q - RW'(1));

  // Both addresses are pure accumulators: the read address just counts, and
  // the write address strides by rows down a destination column, restarting
  // at i+1 (the top of the next destination column) when j wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q  <= '0;
      cols_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      rd_addr <= '0;
      wr_addr <= '0;
    end else if (start) begin
      rows_q  <= rows;
      cols_q  <= cols;
      i_q     <= '0;
      j_q     <= '0;
      rd_addr <= '0;
      wr_addr <= '0;
    end else if (advance) begin
      rd_addr <= rd_addr + AW'(1);
      if (col_wrap) begin
        j_q     <= '0;
        i_q     <= i_q + RW'(1);
        wr_addr <= AW'(i_q) + AW'(1);
      end else begin
        j_q     <= j_q + CW'(1);
        wr_addr <= wr_addr + AW'(rows_q);
      end
    end
  end

endmodule

// File: rtl/transpose_param.sv
// transpose_param
// Runtime-dimensioned matrix transpose engine. Reads Ai (rows x cols,
// row-major) through a memref read port and writes Co (cols x rows,
// row-major) through a memref write port: Co[j*rows+i] = Ai[i*cols+j].
// Ports:
//   clk, rst          : clock, synchronous active-high reset (aborts a transfer)
//   t                 : start pulse, accepted only when idle
//   rows, cols        : dimensions, sampled with an accepted t
//   Ai_p0_*           : read port (address, strobe, data RD_LATENCY cycles later)
//   Co_p0_*           : write port (address, strobe, data)
//   busy              : high from the cycle after t until the done cycle
//   done              : one-cycle completion pulse
module transpose_param
  import transpose_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int MAX_ROWS   = DEF_MAX_ROWS,
  parameter int MAX_COLS   = DEF_MAX_COLS,
  parameter int RD_LATENCY = 1,
  localparam int AW        = addr_width(MAX_ROWS, MAX_COLS),
  localparam int RW        = $clog2(MAX_ROWS + 1),
  localparam int CW        = $clog2(MAX_COLS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t,
  input  logic [RW-1:0]    rows,
  input  logic [CW-1:0]    cols,
  output logic             Ai_p0_addr_en,
  output logic [AW-1:0]    Ai_p0_addr_data,
  output logic             Ai_p0_rd_en,
  input  logic [WIDTH-1:0] Ai_p0_rd_data,
  output logic             Co_p0_addr_en,
  output logic [AW-1:0]    Co_p0_addr_data,
  output logic             Co_p0_wr_en,
  output logic [WIDTH-1:0] Co_p0_wr_data,
  output logic             busy,
  output logic             done
);

  state_t        state;
  logic          start;
  logic          zero_dims;
  logic          last;
  logic          drained;
  logic [AW-1:0] gen_wr_addr;

  // vld[k] marks a read issued k+1 cycles ago; vld[RD_LATENCY] is the write
  // strobe. wa[] carries each read's destination address alongside it.
  logic [RD_LATENCY:0] vld;
  logic [AW-1:0]       wa [RD_LATENCY+1];

  assign start     = (state == IDLE) && t;
  assign zero_dims = (rows == '0) || (cols == '0);

  // Only the final stage may still hold a write when we leave FLUSH; it
  // retires in the same cycle, so DONE lands one cycle after the last write.
  assign drained = ~|vld[RD_LATENCY-1:0];

  transpose_addr_gen #(
    .MAX_ROWS (MAX_ROWS),
    .MAX_COLS (MAX_COLS),
    .AW       (AW)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .advance (Ai_p0_rd_en),
    .rows    (rows),
    .cols    (cols),
    .rd_addr (Ai_p0_addr_data),
    .wr_addr (gen_wr_addr),
    .last    (last)
  );

  // Control FSM with registered read strobe and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      Ai_p0_rd_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (t) begin
            busy <= 1'b1;
            if (zero_dims) begin
              state <= FLUSH;
            end else begin
              state       <= RUN;
              Ai_p0_rd_en <= 1'b1;
            end
          end
        end
        RUN: begin
          if (last) begin
            state       <= FLUSH;
            Ai_p0_rd_en <= 1'b0;
          end
        end
        FLUSH: begin
          if (drained) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Latency pipeline: data is registered in the cycle it arrives, so the
  // write goes out one cycle after the read data becomes valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld           <= '0;
      Co_p0_wr_data <= '0;
      for (int k = 0; k <= RD_LATENCY; k++) begin
        wa[k] <= '0;
      end
    end else begin
      vld   <= {vld[RD_LATENCY-1:0], Ai_p0_rd_en};
      wa[0] <= gen_wr_addr;
      for (int k = 1; k <= RD_LATENCY; k++) begin
        wa[k] <= wa[k-1];
      end
      if (vld[RD_LATENCY-1]) begin
        Co_p0_wr_data <= Ai_p0_rd_data;
      end
    end
  end

  assign Ai_p0_addr_en   = Ai_p0_rd_en;
  assign Co_p0_wr_en     = vld[RD_LATENCY];
  assign Co_p0_addr_en   = vld[RD_LATENCY];
  assign Co_p0_addr_data = wa[RD_LATENCY];

endmodule

// File: tb/tb_transpose_param.sv
// tb_transpose_param
// Runs an RD_LATENCY=1 and an RD_LATENCY=3 engine side by side on the same
// control inputs, each against its own delayed-read memory model, and checks
// the transposed result, strobe counts and cycle timing of every run.
module tb_transpose_param;
  import transpose_pkg::*;

  localparam int W     = DEF_WIDTH;
  localparam int MR    = DEF_MAX_ROWS;
  localparam int MC    = DEF_MAX_COLS;
  localparam int AW    = addr_width(MR, MC);
  localparam int RW    = $clog2(MR + 1);
  localparam int CW    = $clog2(MC + 1);
  localparam int DEPTH = MR * MC;
  localparam logic [W-1:0] JUNK = 32'hDEAD_BEEF;

  typedef struct {
    int           c;
    int           a;
    logic [W-1:0] d;
  } wr_rec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          t;
  logic [RW-1:0] rows;
  logic [CW-1:0] cols;
  logic          rd_en [2];
  logic          raddr_en [2];
  logic [AW-1:0] raddr [2];
  logic [W-1:0]  rd_data [2];
  logic          wr_en [2];
  logic          waddr_en [2];
  logic [AW-1:0] waddr [2];
  logic [W-1:0]  wr_data [2];
  logic          busy [2];
  logic          done [2];

  always #5 clk = ~clk;

  transpose_param #(.WIDTH(W), .MAX_ROWS(MR), .MAX_COLS(MC), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .t(t), .rows(rows), .cols(cols),
    .Ai_p0_addr_en(raddr_en[0]), .Ai_p0_addr_data(raddr[0]), .Ai_p0_rd_en(rd_en[0]),
    .Ai_p0_rd_data(rd_data[0]),
    .Co_p0_addr_en(waddr_en[0]), .Co_p0_addr_data(waddr[0]), .Co_p0_wr_en(wr_en[0]),
    .Co_p0_wr_data(wr_data[0]), .busy(busy[0]), .done(done[0])
  );

  transpose_param #(.WIDTH(W), .MAX_ROWS(MR), .MAX_COLS(MC), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .t(t), .rows(rows), .cols(cols),
    .Ai_p0_addr_en(raddr_en[1]), .Ai_p0_addr_data(raddr[1]), .Ai_p0_rd_en(rd_en[1]),
    .Ai_p0_rd_data(rd_data[1]),
    .Co_p0_addr_en(waddr_en[1]), .Co_p0_addr_data(waddr[1]), .Co_p0_wr_en(wr_en[1]),
    .Co_p0_wr_data(wr_data[1]), .busy(busy[1]), .done(done[1])
  );

  int           cyc = 0;
  int           start_cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] ai_mem [DEPTH];
  logic [W-1:0] pipe [2][3];
  int           rd_cnt [2] = '{0, 0};
  int           rd_last [2] = '{-1, -1};
  int           busy_cnt [2] = '{0, 0};
  int           done_cnt [2] = '{0, 0};
  int           done_last [2] = '{-1, -1};
  int           en_bad [2] = '{0, 0};
  wr_rec_t      wlog0 [$];
  wr_rec_t      wlog1 [$];
  int           snap_rd [2];
  int           snap_w [2];
  int           snap_busy [2];
  int           snap_done [2];
  int           snap_en [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic wr_rec_t make_rec(input int c, input int a, input logic [W-1:0] d);
    wr_rec_t r;
    r.c = c;
    r.a = a;
    r.d = d;
    return r;
  endfunction

  function automatic int wlog_size(input int k);
    return (k == 0) ? wlog0.size() : wlog1.size();
  endfunction

  function automatic wr_rec_t wlog_get(input int k, input int i);
    return (k == 0) ? wlog0[i] : wlog1[i];
  endfunction

  // Memory models and observers, sampled on the falling edge. Read data for
  // a strobe seen in cycle c is presented from cycle c+latency.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      rd_data[k] <= (k == 0) ? pipe[k][0] : pipe[k][2];
      pipe[k][2] <= pipe[k][1];
      pipe[k][1] <= pipe[k][0];
      pipe[k][0] <= (rd_en[k] === 1'b1) ? ai_mem[raddr[k]] : JUNK;
      if (rd_en[k] === 1'b1) begin
        rd_cnt[k]  <= rd_cnt[k] + 1;
        rd_last[k] <= cyc;
      end
      if (wr_en[k] === 1'b1) begin
        if (k == 0) wlog0.push_back(make_rec(cyc, int'(waddr[k]), wr_data[k]));
        else        wlog1.push_back(make_rec(cyc, int'(waddr[k]), wr_data[k]));
      end
      if (busy[k] === 1'b1) busy_cnt[k] <= busy_cnt[k] + 1;
      if (done[k] === 1'b1) begin
        done_cnt[k]  <= done_cnt[k] + 1;
        done_last[k] <= cyc;
      end
      if ((raddr_en[k] !== rd_en[k]) || (waddr_en[k] !== wr_en[k])) en_bad[k] <= en_bad[k] + 1;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill_ai(input int pat);
    for (int k = 0; k < DEPTH; k++) begin
      if (pat == 0)      ai_mem[k] = W'(k);
      else if (pat == 1) ai_mem[k] = W'(k + 100);
      else               ai_mem[k] = $urandom;
    end
  endtask

  task automatic take_snapshot();
    for (int k = 0; k < 2; k++) begin
      snap_rd[k]   = rd_cnt[k];
      snap_w[k]    = wlog_size(k);
      snap_busy[k] = busy_cnt[k];
      snap_done[k] = done_cnt[k];
      snap_en[k]   = en_bad[k];
    end
  endtask

  // Pulses t for one cycle; that cycle is cycle 0 of the run.
  task automatic apply_stimulus(input int r, input int c);
    @(negedge clk);
    take_snapshot();
    start_cyc = cyc;
    rows = RW'(r);
    cols = CW'(c);
    t = 1'b1;
    @(negedge clk);
    t = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (((done_cnt[0] == snap_done[0]) || (done_cnt[1] == snap_done[1])) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    tick(6);
  endtask

  // Expected behaviour straight from the transpose rules: n reads and n
  // writes, write m carries source element m to (m%c)*r + m/c, and the
  // final image satisfies Co[j*r+i] == Ai[i*c+j].
  task automatic check_run(input int r, input int c, input string tag);
    for (int k = 0; k < 2; k++) begin
      int           n;
      int           lat;
      int           exp_done;
      int           nw;
      int           bad_addr;
      int           bad_data;
      wr_rec_t      rec;
      logic [W-1:0] co [DEPTH];
      n        = r * c;
      lat      = (k == 0) ? 1 : 3;
      exp_done = (n == 0) ? 2 : n + lat + 2;
      nw       = wlog_size(k) - snap_w[k];
      bad_addr = 0;
      bad_data = 0;
      for (int a = 0; a < DEPTH; a++) co[a] = 'x;
      check_output($sformatf("%s/L%0d reads", tag, lat), rd_cnt[k] - snap_rd[k], n);
      check_output($sformatf("%s/L%0d writes", tag, lat), nw, n);
      check_output($sformatf("%s/L%0d done count", tag, lat), done_cnt[k] - snap_done[k], 1);
      check_output($sformatf("%s/L%0d done cycle", tag, lat), done_last[k] - start_cyc, exp_done);
      check_output($sformatf("%s/L%0d busy cycles", tag, lat), busy_cnt[k] - snap_busy[k], exp_done);
      check_output($sformatf("%s/L%0d addr_en match", tag, lat), en_bad[k] - snap_en[k], 0);
      check_output($sformatf("%s/L%0d idle after", tag, lat), {busy[k], done[k], rd_en[k], wr_en[k]}, 0);
      if (n > 0) begin
        rec = wlog_get(k, snap_w[k]);
        check_output($sformatf("%s/L%0d first write cycle", tag, lat), rec.c - start_cyc, lat + 2);
        rec = wlog_get(k, wlog_size(k) - 1);
        check_output($sformatf("%s/L%0d last write cycle", tag, lat), rec.c - start_cyc, n + lat + 1);
      end
      for (int m = 0; m < nw; m++) begin
        rec = wlog_get(k, snap_w[k] + m);
        if ((c == 0) || (rec.a != (m % c) * r + m / c)) bad_addr++;
        if ((m >= DEPTH) || (rec.d !== ai_mem[m])) bad_data++;
        if ((rec.a >= 0) && (rec.a < DEPTH)) co[rec.a] = rec.d;
      end
      for (int i = 0; i < r; i++) begin
        for (int j = 0; j < c; j++) begin
          if (co[j * r + i] !== ai_mem[i * c + j]) bad_data++;
        end
      end
      check_output($sformatf("%s/L%0d write addr order", tag, lat), bad_addr, 0);
      check_output($sformatf("%s/L%0d Co contents", tag, lat), bad_data, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    int c;
    int abort_ref;
    rst  = 1'b1;
    t    = 1'b0;
    rows = '0;
    cols = '0;
    tick(3);

    $display("[TB] reset state");
    for (int k = 0; k < 2; k++) begin
      check_output($sformatf("reset strobes/status k%0d", k),
                   {raddr_en[k], rd_en[k], waddr_en[k], wr_en[k], busy[k], done[k]}, 0);
      check_output($sformatf("reset addresses k%0d", k), {raddr[k], waddr[k]}, 0);
      check_output($sformatf("reset wr_data k%0d", k), wr_data[k], 0);
    end
    rst = 1'b0;
    tick(2);

    $display("[TB] 8x8 ramp");
    fill_ai(0);
    apply_stimulus(8, 8);
    wait_done(200);
    check_run(8, 8, "8x8");

    $display("[TB] 4x16 offset ramp");
    fill_ai(1);
    apply_stimulus(4, 16);
    wait_done(200);
    check_run(4, 16, "4x16");

    $display("[TB] degenerate shapes");
    fill_ai(2);
    apply_stimulus(1, 16);
    wait_done(100);
    check_run(1, 16, "1x16");
    fill_ai(2);
    apply_stimulus(16, 1);
    wait_done(100);
    check_run(16, 1, "16x1");
    apply_stimulus(0, 5);
    wait_done(50);
    check_run(0, 5, "0x5");
    apply_stimulus(5, 0);
    wait_done(50);
    check_run(5, 0, "5x0");
    apply_stimulus(16, 16);
    wait_done(400);
    check_run(16, 16, "16x16");

    $display("[TB] random shapes");
    for (int n = 0; n < 3; n++) begin
      r = $urandom_range(1, MR);
      c = $urandom_range(1, MC);
      fill_ai(2);
      apply_stimulus(r, c);
      wait_done(400);
      check_run(r, c, $sformatf("rand%0dx%0d", r, c));
    end

    $display("[TB] t retriggered while busy");
    fill_ai(2);
    apply_stimulus(8, 8);
    while (cyc - start_cyc < 10) @(negedge clk);
    rows = RW'(2);
    t    = 1'b1;
    @(negedge clk);
    t = 1'b0;
    wait_done(200);
    check_run(8, 8, "retrig");

    $display("[TB] reset aborts a transfer");
    fill_ai(2);
    apply_stimulus(8, 8);
    abort_ref = start_cyc;
    while (cyc - abort_ref < 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check_output($sformatf("abort outputs cleared k%0d", k),
                   {rd_en[k], wr_en[k], busy[k], done[k], raddr[k], waddr[k]}, 0);
    end
    while (cyc - abort_ref < 29) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int late;
      wr_rec_t rec;
      late = 0;
      for (int m = snap_w[k]; m < wlog_size(k); m++) begin
        rec = wlog_get(k, m);
        if (rec.c - abort_ref >= 21) late++;
      end
      if (rd_last[k] - abort_ref >= 21) late++;
      check_output($sformatf("abort late strobes k%0d", k), late, 0);
      check_output($sformatf("abort reads before k%0d", k), rd_cnt[k] - snap_rd[k], 20);
      check_output($sformatf("abort writes before k%0d", k), wlog_size(k) - snap_w[k],
                   (k == 0) ? 18 : 16);
      check_output($sformatf("abort no done k%0d", k), done_cnt[k] - snap_done[k], 0);
    end
    apply_stimulus(8, 8);
    wait_done(200);
    check_run(8, 8, "after abort");
    check_output("after abort done abs L1", done_last[0] - abort_ref, 97);
    check_output("after abort done abs L3", done_last[1] - abort_ref, 99);

    $display("[TB] t together with rst");
    @(negedge clk);
    take_snapshot();
    rows = RW'(4);
    cols = CW'(4);
    rst  = 1'b1;
    t    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    t   = 1'b0;
    tick(6);
    for (int k = 0; k < 2; k++) begin
      check_output($sformatf("rst+t no busy k%0d", k), busy_cnt[k] - snap_busy[k], 0);
      check_output($sformatf("rst+t no reads k%0d", k), rd_cnt[k] - snap_rd[k], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/transpose_param.md
Name: transpose_param

Overview:
- Parametrised, runtime-dimensioned matrix transpose engine. Successor to the fixed-size transpose kernel.
- Streams Ai (row-major, rows x cols) through a memref read port. Writes Co (row-major, cols x rows) through a memref write port: Co[j*rows+i] = Ai[i*cols+j].
- Sits between the memref_rd/memref_wr bank models (or real BRAM ports) and the control sequencer. Started by a one-cycle `t` pulse; reports completion with `done`.
- Adds over the fixed kernel: runtime dims, configurable read latency, busy/done status, defined restart/abort rules.

Parameters:
- WIDTH, 32, element width in bits
- MAX_ROWS, 16, largest supported row count (power of two not required)
- MAX_COLS, 16, largest supported column count
- RD_LATENCY, 1, cycles from Ai_p0_rd_en to valid Ai_p0_rd_data (>=1)
- AW, $clog2(MAX_ROWS*MAX_COLS), address width (derived, localparam)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- t  in  1  start pulse, sampled when idle
- rows  in  $clog2(MAX_ROWS+1)  row count of Ai, sampled with t
- cols  in  $clog2(MAX_COLS+1)  column count of Ai, sampled with t
- Ai_p0_addr_en  out  1  read address valid (equals Ai_p0_rd_en)
- Ai_p0_addr_data  out  AW  read address
- Ai_p0_rd_en  out  1  read strobe
- Ai_p0_rd_data  in  WIDTH  read data, valid RD_LATENCY cycles after strobe
- Co_p0_addr_en  out  1  write address valid (equals Co_p0_wr_en)
- Co_p0_addr_data  out  AW  write address
- Co_p0_wr_en  out  1  write strobe
- Co_p0_wr_data  out  WIDTH  write data
- busy  out  1  high from the cycle after accepted t until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0. State IDLE. Counters cleared. Reset takes effect on any cycle, including mid-transfer.
- Reset mid-transfer aborts immediately. The next cycle has no rd_en/wr_en. In-flight read data is discarded. No done pulse.
- States:
  - IDLE: t=1 latches rows/cols and moves to RUN. If rows==0 or cols==0, moves to FLUSH with zero reads issued.
  - RUN: issues one read per cycle, row-major: i outer 0..rows-1, j inner 0..cols-1. Ai_p0_addr_data = i*cols+j. After the last read (i=rows-1, j=cols-1), moves to FLUSH.
  - FLUSH: waits until the write pipeline is empty, then moves to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Address arithmetic: the read address is an incrementing counter, not a multiply. The write address is a separate accumulator: +rows per step, and on column wrap it reloads to i+1. All arithmetic is AW bits wide. Dims are guaranteed <= MAX by the caller; no range check.
- Pipeline:
  - Read issued in cycle c. Ai_p0_rd_data is valid in cycle c+RD_LATENCY and is registered.
  - Co_p0_wr_en=1 in cycle c+RD_LATENCY+1, carrying that data and its matching write address. The address travels through a RD_LATENCY+1 deep shift register alongside a valid bit.
- Timing: t accepted in cycle 0. First rd_en in cycle 1. N = rows*cols reads occupy cycles 1..N. Last write in cycle N+RD_LATENCY+1. done in cycle N+RD_LATENCY+2. busy is high in cycles 1..N+RD_LATENCY+2, and falls with done.
- Zero dims: done asserts in cycle 2 (IDLE -> FLUSH -> DONE). No memory strobes.
- t while busy (RUN/FLUSH/DONE) is ignored; rows/cols are not resampled. t in the same cycle as rst: reset wins.
- Exactly one write per read; no write is duplicated or dropped. rd_en/wr_en are never asserted while IDLE.

Decomposition:
- Package transpose_pkg:
  - state enum {IDLE, RUN, FLUSH, DONE}
  - function addr_width(rows, cols)
  - default WIDTH/MAX constants shared with the benches
- Sub-module transpose_addr_gen:
  - i/j counters, read-address counter, write-address accumulator
  - last-element flag
  - driven by start/advance, dims latched inside
- The top level holds the FSM, latency shift register, data register and status outputs.

Test Plan:
- 8x8, Ai[k]=k, t at cycle 0 -> Co[j*8+i]=i*8+j for all 64 entries. First wr_en in cycle 3. done in cycle 67 with RD_LATENCY=1.
- Non-square 4x16, Ai[k]=k+100 -> Co[j*4+i]=i*16+j+100. Exactly 64 writes. Write addresses follow 0,4,8..60,1,5...
- Degenerate 1x16 and 16x1 -> Co equals Ai (identity layout). rows=0, cols=5 -> no strobes, done in cycle 2.
- RD_LATENCY=3 build, 8x8 -> same Co contents. done in cycle 69. Read model delays data 3 cycles.
- t pulsed again in cycle 10 of an 8x8 run with rows=2 applied -> ignored. Still exactly 64 writes and one done.
- rst asserted in cycle 20 of an 8x8 run -> no strobes from cycle 21, no done. A fresh t at cycle 30 completes correctly with done in cycle 97.
